// File: rtl/labkit.sv
// rtl/labkit.sv - traffic-light controller with walk phase and reprogrammable timing
module labkit #(
  parameter int CLK_DIVIDE = 100000
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Sensor,
  input  logic       Walk_Request,
  input  logic       Reprogram,
  input  logic [1:0] Time_Parameter_Selector,
  input  logic [3:0] Time_Value,
  output logic [6:0] LEDs
);

  localparam logic [2:0] MAIN_GREEN     = 3'd0;
  localparam logic [2:0] MAIN_YELLOW    = 3'd1;
  localparam logic [2:0] WALK           = 3'd2;
  localparam logic [2:0] SIDE_GREEN     = 3'd3;
  localparam logic [2:0] SIDE_GREEN_EXT = 3'd4;
  localparam logic [2:0] SIDE_YELLOW    = 3'd5;

  localparam int DIV_W = (CLK_DIVIDE > 1) ? $clog2(CLK_DIVIDE) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIVIDE - 1);

  logic             sensor_s1, sensor_s2;
  logic             walk_s1, walk_s2;
  logic             rep_s1, rep_s2, rep_d;
  logic             rep_edge;
  logic [3:0]       t_base, t_ext, t_yel;
  logic [3:0]       t_base_n, t_ext_n, t_yel_n;
  logic [2:0]       state, state_n;
  logic             enter;
  logic             walk_latch;
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       timer;
  logic             tick, expire;

  // Durations come from the parameter values that will be stored after this edge.
  function automatic logic [4:0] dur_of(input logic [2:0] s, input logic [3:0] b,
                                        input logic [3:0] e, input logic [3:0] y);
    logic [4:0] d;
    case (s)
      MAIN_GREEN:                d = {b, 1'b0};
      MAIN_YELLOW, SIDE_YELLOW:  d = {1'b0, y};
      WALK, SIDE_GREEN_EXT:      d = {1'b0, e};
      default:                   d = {1'b0, b};
    endcase
    return (d == 5'd0) ? 5'd1 : d;
  endfunction

  function automatic logic [6:0] led_of(input logic [2:0] s);
    case (s)
      MAIN_GREEN:                 return 7'h18;
      MAIN_YELLOW:                return 7'h28;
      WALK:                       return 7'h49;
      SIDE_GREEN, SIDE_GREEN_EXT: return 7'h42;
      SIDE_YELLOW:                return 7'h44;
      default:                    return 7'h18;
    endcase
  endfunction

  assign rep_edge = rep_s2 & ~rep_d;
  assign tick     = (div_cnt == DIV_LAST);
  assign expire   = tick && (timer == 5'd1);

  always_comb begin
    t_base_n = t_base;
    t_ext_n  = t_ext;
    t_yel_n  = t_yel;
    if (rep_edge) begin
      case (Time_Parameter_Selector)
        2'b00:   t_base_n = Time_Value;
        2'b01:   t_ext_n  = Time_Value;
        2'b10:   t_yel_n  = Time_Value;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    enter   = 1'b0;
    if (rep_edge) begin
      state_n = MAIN_GREEN;
      enter   = 1'b1;
    end else if (expire) begin
      enter = 1'b1;
      case (state)
        MAIN_GREEN:     state_n = MAIN_YELLOW;
        MAIN_YELLOW:    state_n = (walk_latch | walk_s2) ? WALK : SIDE_GREEN;
        WALK:           state_n = SIDE_GREEN;
        SIDE_GREEN:     state_n = sensor_s2 ? SIDE_GREEN_EXT : SIDE_YELLOW;
        SIDE_GREEN_EXT: state_n = SIDE_YELLOW;
        default:        state_n = MAIN_GREEN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      sensor_s1  <= 1'b0;
      sensor_s2  <= 1'b0;
      walk_s1    <= 1'b0;
      walk_s2    <= 1'b0;
      rep_s1     <= 1'b0;
      rep_s2     <= 1'b0;
      rep_d      <= 1'b0;
      t_base     <= 4'd6;
      t_ext      <= 4'd3;
      t_yel      <= 4'd2;
      state      <= MAIN_GREEN;
      LEDs       <= 7'h18;
      walk_latch <= 1'b0;
      div_cnt    <= '0;
      timer      <= 5'd12;
    end else begin
      sensor_s1 <= Sensor;
      sensor_s2 <= sensor_s1;
      walk_s1   <= Walk_Request;
      walk_s2   <= walk_s1;
      rep_s1    <= Reprogram;
      rep_s2    <= rep_s1;
      rep_d     <= rep_s2;
      t_base    <= t_base_n;
      t_ext     <= t_ext_n;
      t_yel     <= t_yel_n;
      state     <= state_n;
      LEDs      <= led_of(state_n);
      // Entering WALK consumes the request; otherwise requests keep accumulating.
      if (enter && state_n == WALK)
        walk_latch <= 1'b0;
      else if (walk_s2)
        walk_latch <= 1'b1;
      if (enter) begin
        div_cnt <= '0;
        timer   <= dur_of(state_n, t_base_n, t_ext_n, t_yel_n);
      end else begin
        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
        if (tick)
          timer <= timer - 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_labkit.sv
// tb/tb_labkit.sv - directed scoreboard bench for labkit with CLK_DIVIDE=10
module tb_labkit;

  typedef struct {
    logic [6:0] leds;
    int         cycles;
  } phase_t;

  localparam int LIMIT = 2000;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Sensor = 1'b0;
  logic       Walk_Request = 1'b0;
  logic       Reprogram = 1'b0;
  logic [1:0] Time_Parameter_Selector = 2'b00;
  logic [3:0] Time_Value = 4'd0;
  logic [6:0] LEDs;

  int checks = 0;
  int errors = 0;
  phase_t sb[$];

  labkit #(.CLK_DIVIDE(10)) dut (
    .clk(clk),
    .Reset(Reset),
    .Sensor(Sensor),
    .Walk_Request(Walk_Request),
    .Reprogram(Reprogram),
    .Time_Parameter_Selector(Time_Parameter_Selector),
    .Time_Value(Time_Value),
    .LEDs(LEDs)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [6:0] l, input int c);
    phase_t p;
    p.leds   = l;
    p.cycles = c;
    sb.push_back(p);
  endtask

  // Each popped phase must be showing now; its length is counted in sampled cycles.
  task automatic run_queue(input string name);
    phase_t p;
    int n;
    int idx;
    idx = 0;
    while (sb.size() > 0) begin
      p = sb.pop_front();
      check($sformatf("%s_p%0d_leds", name, idx), {25'd0, LEDs}, {25'd0, p.leds});
      n = 0;
      while (LEDs === p.leds && n < LIMIT) begin
        n++;
        @(negedge clk);
      end
      check($sformatf("%s_p%0d_cycles", name, idx), n, p.cycles);
      idx++;
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    #1 Reset = 1'b0;
    Walk_Request = 1'b0;
    Reprogram    = 1'b0;
    #1 check({name, "_async_reset"}, {25'd0, LEDs}, 32'h18);
    @(negedge clk);
    Reset = 1'b1;
  endtask

  initial begin
    // Reset and default cycle
    do_reset("reset");
    push(7'h18, 120); push(7'h28, 20); push(7'h42, 60); push(7'h44, 20); push(7'h18, 120);
    run_queue("reset");

    // Walk request during MAIN_GREEN
    do_reset("walk");
    repeat (3) @(negedge clk);
    Walk_Request = 1'b1;
    repeat (2) @(negedge clk);
    Walk_Request = 1'b0;
    push(7'h18, 115); push(7'h28, 20); push(7'h49, 30); push(7'h42, 60);
    push(7'h44, 20);  push(7'h18, 120); push(7'h28, 20); push(7'h42, 60);
    run_queue("walk");

    // Sensor held: one extension
    Sensor = 1'b1;
    do_reset("sensor");
    push(7'h18, 120); push(7'h28, 20); push(7'h42, 90); push(7'h44, 20); push(7'h18, 120);
    run_queue("sensor");
    Sensor = 1'b0;

    // Reprogram tBASE=2 during SIDE_GREEN
    do_reset("reprog");
    push(7'h18, 120); push(7'h28, 20);
    run_queue("reprog_pre");
    check("reprog_in_side_green", {25'd0, LEDs}, 32'h42);
    Time_Parameter_Selector = 2'b00;
    Time_Value = 4'd2;
    Reprogram  = 1'b1;
    repeat (2) @(negedge clk);
    check("reprog_not_yet", {25'd0, LEDs}, 32'h42);
    @(negedge clk);
    check("reprog_latency", {25'd0, LEDs}, 32'h18);
    Reprogram = 1'b0;
    push(7'h18, 40); push(7'h28, 20); push(7'h42, 20); push(7'h44, 20); push(7'h18, 40);
    run_queue("reprog");

    // Selector 11: restart only
    Time_Parameter_Selector = 2'b11;
    Time_Value = 4'd9;
    Reprogram  = 1'b1;
    repeat (2) @(negedge clk);
    check("sel11_not_yet", {25'd0, LEDs}, 32'h28);
    @(negedge clk);
    check("sel11_latency", {25'd0, LEDs}, 32'h18);
    Reprogram = 1'b0;
    push(7'h18, 40); push(7'h28, 20); push(7'h42, 20);
    run_queue("sel11");

    // tYEL=0 behaves as one second
    do_reset("zero");
    Time_Parameter_Selector = 2'b10;
    Time_Value = 4'd0;
    Reprogram  = 1'b1;
    repeat (3) @(negedge clk);
    Reprogram = 1'b0;
    push(7'h18, 120); push(7'h28, 10); push(7'h42, 60); push(7'h44, 10); push(7'h18, 120);
    run_queue("zero");

    // Reset during WALK restores defaults and clears the walk latch
    do_reset("midrun");
    Time_Parameter_Selector = 2'b01;
    Time_Value   = 4'd7;
    Reprogram    = 1'b1;
    Walk_Request = 1'b1;
    repeat (2) @(negedge clk);
    Walk_Request = 1'b0;
    @(negedge clk);
    Reprogram = 1'b0;
    push(7'h18, 120); push(7'h28, 20);
    run_queue("midrun_pre");
    check("midrun_in_walk", {25'd0, LEDs}, 32'h49);
    repeat (4) @(negedge clk);
    #1 Reset = 1'b0;
    #1 check("midrun_async_reset", {25'd0, LEDs}, 32'h18);
    Sensor = 1'b1;
    @(negedge clk);
    Reset = 1'b1;
    push(7'h18, 120); push(7'h28, 20); push(7'h42, 90); push(7'h44, 20);
    run_queue("midrun_post");
    Sensor = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
